// File: rtl/jit_pipeline_vec_unpack.sv
// -----------------------------------------------------------------------------
// jit_pipeline_vec_unpack
//
// Receive-side unpacker for JIT pipeline vectors. Packed words
// {tag, data, lo8} enter on a valid/ready stream and travel through a
// DEPTH-stage elastic pipeline. The pipeline supports backpressure and
// collapses bubbles. The last stage is split into its fields, and the
// redundant lo8 field is checked against the low bits of data. Words whose
// lo8 disagrees are flagged on out_err and can be counted in err_cnt.
//
// Build option:
//   JIT_UNPACK_ERRCNT_EN  defined   -> err_cnt is a 16-bit saturating count of
//                                      delivered erroneous words
//                         undefined -> err_cnt is tied to zero and has no flops
//
// Ports:
//   sys_clk    in   1                 clock, all state on the rising edge
//   sys_rst_n  in   1                 asynchronous active-low reset
//   in_valid   in   1                 input word valid
//   in_ready   out  1                 block can accept a word this cycle
//   in_vec     in   VW                packed word {tag, data, lo8}
//   out_valid  out  1                 output word valid
//   out_ready  in   1                 consumer accepts the output word
//   out_tag    out  1                 unpacked tag
//   out_data   out  DATA_W            unpacked data
//   out_lo8    out  LO_W              unpacked lo8
//   out_err    out  1                 lo8 != data[LO_W-1:0]; valid with out_valid
//   occupancy  out  $clog2(DEPTH+1)   number of occupied stages
//   err_cnt    out  16                saturating error-word count
// -----------------------------------------------------------------------------
module jit_pipeline_vec_unpack #(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 16,
    parameter int LO_W   = 8,
    localparam int VW    = 1 + DATA_W + LO_W,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VW-1:0]     in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_tag,
    output logic [DATA_W-1:0] out_data,
    output logic [LO_W-1:0]   out_lo8,
    output logic              out_err,
    output logic [OCC_W-1:0]  occupancy,
    output logic [15:0]       err_cnt
);

    // Stage state: one valid bit and one packed word per stage.
    // Stage 0 is nearest the input; stage DEPTH-1 drives the outputs.
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [VW-1:0]    word_q [DEPTH];
    logic [VW-1:0]    word_d [DEPTH];

    // adv[i]:  stage i hands its word downstream (or to the consumer) this cycle.
    // load[i]: stage i may capture from upstream this cycle.
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;

    // Advance is resolved from the output back toward the input. Therefore a
    // transfer at the output lets every full stage behind it move in the same
    // cycle. The full pipe then sustains one word per cycle, and ready stays
    // purely combinational.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = v_q[DEPTH-1] && out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = v_q[i] && (!v_q[i+1] || adv[i+1]);
        end
        load = adv | ~v_q;
    end

    assign in_ready = load[0];

    // Word registers update only when a real word arrives. An emptied stage
    // therefore keeps its last contents, and the output fields hold while
    // the pipe is empty.
    always_comb begin
        v_d    = v_q;
        word_d = word_q;
        if (load[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                word_d[0] = in_vec;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (load[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    word_d[i] = word_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= word_d[i];
            end
        end
    end

    // Field extraction from the last stage.
    logic [VW-1:0] last_word;
    assign last_word = word_q[DEPTH-1];

    assign out_valid = v_q[DEPTH-1];
    assign out_tag   = last_word[VW-1];
    assign out_data  = last_word[VW-2:LO_W];
    assign out_lo8   = last_word[LO_W-1:0];
    assign out_err   = (out_lo8 != out_data[LO_W-1:0]);

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v_q[i]);
        end
    end

`ifdef JIT_UNPACK_ERRCNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    logic [15:0] err_cnt_q;
    logic [15:0] err_cnt_d;

    // A word is counted only when the consumer actually takes it, so a
    // stalled erroneous word is counted exactly once.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_valid && out_ready && out_err) begin
            err_cnt_d = sat_inc16(err_cnt_q);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_jit_pipeline_vec_unpack.sv
module tb_jit_pipeline_vec_unpack;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic        out_tag;
    logic [15:0] out_data;
    logic [7:0]  out_lo8;
    logic        out_err;
    logic [1:0]  occupancy;
    logic [15:0] err_cnt;

`ifdef JIT_UNPACK_ERRCNT_EN
    localparam logic [15:0] ONE_ERR = 16'd1;
`else
    localparam logic [15:0] ONE_ERR = 16'd0;
`endif

    int n_chk;
    int n_fail;

    logic [24:0] sw [10];
    logic [24:0] bw [4];
    int          idx;

    jit_pipeline_vec_unpack #(.DEPTH(3), .DATA_W(16), .LO_W(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .out_data  (out_data),
        .out_lo8   (out_lo8),
        .out_err   (out_err),
        .occupancy (occupancy),
        .err_cnt   (err_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [24:0] out_word();
        return {out_tag, out_data, out_lo8};
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        sw[0] = 25'h101FEFE;
        for (int k = 1; k < 10; k++) begin
            sw[k] = {1'(k % 2), 16'hA000 + 16'(k), 8'(k)};
        end
        bw[0] = 25'h0111111;
        bw[1] = 25'h1222222;
        bw[2] = 25'h0333333;
        bw[3] = 25'h1444444;

        // ---------------- reset ----------------
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        chk("rst_word",      32'(out_word()), 32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        sys_rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // ---------------- single word, latency 3 ----------------
        cyc();
        in_valid  = 1'b1;
        in_vec    = 25'h0234545;
        out_ready = 1'b1;
        #1;
        chk("single_in_ready", 32'(in_ready), 32'd1);
        chk("single_c0_valid", 32'(out_valid), 32'd0);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("single_c1_valid", 32'(out_valid), 32'd0);
        chk("single_c1_occ",   32'(occupancy), 32'd1);
        cyc();
        #1;
        chk("single_c2_valid", 32'(out_valid), 32'd0);
        cyc();
        #1;
        chk("single_c3_valid", 32'(out_valid), 32'd1);
        chk("single_tag",      32'(out_tag),   32'd0);
        chk("single_data",     32'(out_data),  32'h2345);
        chk("single_lo8",      32'(out_lo8),   32'h45);
        chk("single_err",      32'(out_err),   32'd0);
        cyc();
        #1;
        chk("single_c4_valid", 32'(out_valid), 32'd0);

        // ---------------- back-to-back stream of 10 ----------------
        for (int c = 0; c < 13; c++) begin
            cyc();
            if (c < 10) begin
                in_valid = 1'b1;
                in_vec   = sw[c];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 10) chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (c < 3) begin
                chk("stream_lead_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("stream_valid", 32'(out_valid), 32'd1);
                chk("stream_word",  32'(out_word()), 32'(sw[c-3]));
            end
            if (c == 3) begin
                chk("tag_word_tag",  32'(out_tag),  32'd1);
                chk("tag_word_data", 32'(out_data), 32'h01FE);
                chk("tag_word_lo8",  32'(out_lo8),  32'hFE);
                chk("tag_word_err",  32'(out_err),  32'd0);
            end
        end
        cyc();
        #1;
        chk("stream_drained", 32'(out_valid), 32'd0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            in_valid = 1'b1;
            in_vec   = bw[idx];
            #1;
            chk("bp_in_ready", 32'(in_ready), (c < 3) ? 32'd1 : 32'd0);
            if (c >= 3) begin
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_word",  32'(out_word()), 32'(bw[0]));
                chk("bp_full_occ",   32'(occupancy), 32'd3);
            end
            if (in_ready) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd3);
        cyc();
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid",    32'(out_valid), 32'd1);
        chk("bp_out0",             32'(out_word()), 32'(bw[0]));
        cyc();
        in_valid = 1'b0;
        #1;
        chk("bp_out1", 32'(out_word()), 32'(bw[1]));
        chk("bp_occ3", 32'(occupancy), 32'd3);
        cyc();
        #1;
        chk("bp_out2", 32'(out_word()), 32'(bw[2]));
        chk("bp_occ2", 32'(occupancy), 32'd2);
        cyc();
        #1;
        chk("bp_out3", 32'(out_word()), 32'(bw[3]));
        chk("bp_occ1", 32'(occupancy), 32'd1);
        cyc();
        #1;
        chk("bp_empty_valid", 32'(out_valid), 32'd0);
        chk("bp_empty_occ",   32'(occupancy), 32'd0);

        // ---------------- error word ----------------
        cyc();
        in_valid = 1'b1;
        in_vec   = 25'h0234546;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        out_ready = 1'b0;
        #1;
        chk("err_valid",       32'(out_valid), 32'd1);
        chk("err_flag",        32'(out_err),   32'd1);
        chk("err_lo8",         32'(out_lo8),   32'h46);
        chk("err_cnt_stalled", 32'(err_cnt),   32'd0);
        cyc();
        #1;
        chk("err_flag_hold",   32'(out_err),   32'd1);
        chk("err_cnt_stall2",  32'(err_cnt),   32'd0);
        cyc();
        out_ready = 1'b1;
        #1;
        chk("err_xfer_valid",  32'(out_valid), 32'd1);
        cyc();
        out_ready = 1'b0;
        #1;
        chk("err_after_valid", 32'(out_valid), 32'd0);
        chk("err_cnt_after",   32'(err_cnt),   32'(ONE_ERR));
        cyc();
        #1;
        chk("err_cnt_hold",    32'(err_cnt),   32'(ONE_ERR));

        // ---------------- reset mid-flight ----------------
        cyc();
        in_valid = 1'b1;
        in_vec   = 25'h0234546;
        cyc();
        in_vec   = 25'h0ABCDCD;
        cyc();
        in_valid = 1'b0;
        #1;
        chk("mid_occ2", 32'(occupancy), 32'd2);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_occ",   32'(occupancy), 32'd0);
        chk("mid_rst_cnt",   32'(err_cnt),   32'd0);
        cyc();
        cyc();
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end
        chk("mid_cnt_after", 32'(err_cnt), 32'd0);

`ifdef JIT_UNPACK_ERRCNT_EN
        // ---------------- counter saturation ----------------
        out_ready = 1'b1;
        for (int c = 0; c < 65537; c++) begin
            cyc();
            in_valid = 1'b1;
            in_vec   = 25'h0234546;
        end
        cyc();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) cyc();
        chk("sat_value", 32'(err_cnt), 32'hFFFF);
        cyc();
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) cyc();
        chk("sat_hold", 32'(err_cnt), 32'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jit_pipeline_vec_unpack.md
Name: jit_pipeline_vec_unpack

Overview:
- Receive-side counterpart of the JIT pipeline-vector packer.
- Accepts packed words {tag, data, lo8} from a valid/ready stream and carries them through a DEPTH-stage elastic pipeline with backpressure and bubble collapsing.
- Unpacks each word into fields and checks the redundant lo8 field against data[LO_W-1:0].
- Sits between a packed-vector producer and field-level consumers; flags and counts corrupt words.

Parameters:
- DEPTH, 3, number of pipeline stages (≥1); minimum in-to-out latency in cycles.
- DATA_W, 16, width of data field.
- LO_W, 8, width of lo8 field (≤ DATA_W).
- (derived) VW = 1+DATA_W+LO_W = 25 with defaults; packing is tag=[VW-1], data=[VW-2:LO_W], lo8=[LO_W-1:0].

Ports:
- sys_clk  in  1  clock, all state on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept this cycle.
- in_vec  in  VW  packed word.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts.
- out_tag  out  1  unpacked tag.
- out_data  out  DATA_W  unpacked data.
- out_lo8  out  LO_W  unpacked lo8.
- out_err  out  1  lo8 != data[LO_W-1:0] for current output word; meaningful only when out_valid=1.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages.
- err_cnt  out  16  saturating count of erroneous words delivered; macro-dependent, see Optional Feature.

Behaviour:
- Reset (async assert, sync release on sys_clk):
  - All stage valid bits 0, stage data 0.
  - Outputs: out_valid=0, out_tag=0, out_data=0, out_lo8=0, out_err=0, occupancy=0, err_cnt=0.
  - in_ready=1 once reset is deasserted.
  - Reset mid-stream discards all in-flight words without delivering them.
- Pipeline: stages s[0..DEPTH-1], each holding valid v[i] and a VW-bit word.
  - Stage i advances when v[i] and (i==DEPTH-1 ? out_ready : (!v[i+1] || stage i+1 advances)).
  - Stage i loads from stage i-1 (or from input for i=0) when its own contents advance or it is empty.
  - in_ready = !v[0] || stage 0 advances. This is combinational from out_ready through the chain; no registered ready.
  - Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- Latency:
  - An accepted word appears at the output exactly DEPTH cycles later when no stall occurs.
  - Bubbles collapse: a stalled output lets upstream stages fill, with up to DEPTH words held.
- Full: all v[i]=1 and out_ready=0 → in_ready=0. Simultaneous out transfer and in transfer on a full pipe is allowed, giving 1 word/cycle throughput.
- Empty: out_valid=0; output field values are don't-care but hold the last stage register contents.
- Stability: while out_valid=1 and out_ready=0, all out_* fields hold stable.
- Field extraction and out_err are combinational from the last stage register.
- occupancy = popcount(v), updated each cycle.
- err_cnt increments by 1 on each output transfer with out_err=1, saturating at 0xFFFF.
- No reordering or duplication: words exit in accept order, each exactly once.

Optional Feature:
- Macro JIT_UNPACK_ERRCNT_EN.
- Defined: err_cnt is implemented as specified.
- Undefined: err_cnt is tied to 0 with no counter flops, and out_err is still produced.

Test Plan:
- Single word: after reset, in_vec=25'h0234545 (tag0, data 0x2345, lo8 0x45), out_ready=1 → out_valid rises 3 cycles later with tag=0, data=16'h2345, lo8=8'h45, out_err=0.
- Tag word: in_vec=25'h101FEFE → tag=1, data=16'h01FE, lo8=8'hFE, err=0; back-to-back stream of 10 words with out_ready=1 → 10 outputs on 10 consecutive cycles, in order.
- Backpressure: out_ready=0, push words until in_ready=0 → exactly 3 accepted, occupancy=3; raise out_ready → 3 words emerge in order, and in_ready returns to 1 in the same cycle as the first output transfer.
- Error: in_vec=25'h0234546 (lo8 0x46 ≠ 0x45) → out_err=1 at output; with JIT_UNPACK_ERRCNT_EN, err_cnt=1 after the transfer and is unchanged while out_ready=0; without the macro, err_cnt stays 0.
- Reset mid-flight: 2 words in pipe, assert sys_rst_n=0 asynchronously → out_valid=0, occupancy=0, err_cnt=0 immediately; after release, no stale words appear.
- Saturation (macro on): deliver 65537 erroneous words → err_cnt=16'hFFFF and holds.
